// File: rtl/gfx256_wbm_read_arb.sv
// gfx256_wbm_read_arb
// Read-side Wishbone master for the 256-bit graphics pipeline. It arbitrates
// between the z-buffer channel (clip stage) and the texture channel (fragment
// stage), runs one classic Wishbone read per grant, and returns the whole
// memory line with a one-cycle ack pulse on the granted channel.
// Optional single-line read cache: define GFX256_RD_CACHE_EN.
module gfx256_wbm_read_arb #(
   parameter int unsigned MDW  = 256,
   parameter int unsigned TO_W = 10
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               z_request_i,
   input  logic [31:0]        z_addr_i,
   input  logic [MDW/8-1:0]   z_sel_i,
   output logic               z_ack_o,
   output logic [MDW-1:0]     z_data_o,
   input  logic               tex_request_i,
   input  logic [31:0]        tex_addr_i,
   input  logic [MDW/8-1:0]   tex_sel_i,
   output logic               tex_ack_o,
   output logic [MDW-1:0]     tex_data_o,
   output logic               busy_o,
   output logic               err_o,
   input  logic               cache_inv_i,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic [2:0]         wbm_cti_o,
   output logic [1:0]         wbm_bte_o,
   output logic [31:0]        wbm_adr_o,
   output logic [MDW/8-1:0]   wbm_sel_o,
   input  logic [MDW-1:0]     wbm_dat_i,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i
);

   localparam int unsigned SW  = MDW / 8;
   localparam int unsigned OFS = $clog2(SW);
   // Last counter value before the timeout fires; the cycle seeing it is the
   // (2^TO_W-1)-th BUS cycle.
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE,
      ST_HIT
   } state_t;

   state_t              state_q, state_d;

   logic                gnt_tex_q;
   logic                prio_tex_q;
   logic                err_q;
   logic [31:OFS]       adr_q;
   logic [SW-1:0]       sel_q;
   logic [TO_W-1:0]     to_cnt_q;
   logic [MDW-1:0]      z_data_q;
   logic [MDW-1:0]      tex_data_q;

   logic                any_req;
   logic                pick_tex;
   logic [31:OFS]       req_tag;
   logic                timeout;
   logic                bus_end;
   logic                bus_fail;
   logic                cache_hit;
   logic [MDW-1:0]      hit_data;
   logic                unused_ok;

   assign any_req  = z_request_i | tex_request_i;
   // z wins a tie unless the previous contested grant went to z
   assign pick_tex = tex_request_i & (~z_request_i | prio_tex_q);
   assign req_tag  = pick_tex ? tex_addr_i[31:OFS] : z_addr_i[31:OFS];
   assign timeout  = (to_cnt_q == TO_LAST);
   assign bus_end  = wbm_ack_i | wbm_err_i | timeout;
   assign bus_fail = wbm_err_i | timeout;

   // Line offset bits never reach the bus; cache_inv_i is idle without the cache
   assign unused_ok = ^{cache_inv_i, z_addr_i[OFS-1:0], tex_addr_i[OFS-1:0]};

`ifdef GFX256_RD_CACHE_EN
   logic                line_valid_q;
   logic [31:OFS]       line_tag_q;
   logic [MDW-1:0]      line_data_q;

   assign cache_hit = line_valid_q & (line_tag_q == req_tag);
   assign hit_data  = line_data_q;

   // Shared line register: filled by every clean bus completion, invalidate wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_valid_q <= 1'b0;
         line_tag_q   <= '0;
         line_data_q  <= '0;
      end else if (cache_inv_i) begin
         line_valid_q <= 1'b0;
      end else if (state_q == ST_BUS && wbm_ack_i && !bus_fail) begin
         line_valid_q <= 1'b1;
         line_tag_q   <= adr_q;
         line_data_q  <= wbm_dat_i;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_data  = '0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; DONE always returns to IDLE so a stale request is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = cache_hit ? ST_HIT : ST_BUS;
         ST_BUS:  if (bus_end) state_d = ST_DONE;
         ST_HIT:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state and the latched grant/datapath registers
   always_comb begin
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      z_ack_o    = 1'b0;
      tex_ack_o  = 1'b0;
      err_o      = 1'b0;
      busy_o     = (state_q != ST_IDLE);
      wbm_cti_o  = 3'b000;
      wbm_bte_o  = 2'b00;
      wbm_adr_o  = {adr_q, {OFS{1'b0}}};
      wbm_sel_o  = sel_q;
      z_data_o   = z_data_q;
      tex_data_o = tex_data_q;
      case (state_q)
         ST_BUS: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
         end
         ST_DONE: begin
            z_ack_o   = ~gnt_tex_q;
            tex_ack_o = gnt_tex_q;
            err_o     = err_q;
         end
         default: ;
      endcase
   end

   // Grant latch, round-robin pointer, timeout counter and line data capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_tex_q  <= 1'b0;
         prio_tex_q <= 1'b0;
         err_q      <= 1'b0;
         adr_q      <= '0;
         sel_q      <= '0;
         to_cnt_q   <= '0;
         z_data_q   <= '0;
         tex_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_tex_q <= pick_tex;
                  adr_q     <= req_tag;
                  sel_q     <= pick_tex ? tex_sel_i : z_sel_i;
                  to_cnt_q  <= '0;
                  err_q     <= 1'b0;
                  // pointer only moves on a contested grant
                  if (z_request_i && tex_request_i) prio_tex_q <= ~pick_tex;
               end
            end
            ST_BUS: begin
               to_cnt_q <= to_cnt_q + 1'b1;
               if (bus_end) begin
                  err_q <= bus_fail;
                  if (gnt_tex_q) tex_data_q <= bus_fail ? '0 : wbm_dat_i;
                  else           z_data_q   <= bus_fail ? '0 : wbm_dat_i;
               end
            end
            ST_HIT: begin
               err_q <= 1'b0;
               if (gnt_tex_q) tex_data_q <= hit_data;
               else           z_data_q   <= hit_data;
            end
            default: ;
         endcase
      end
   end

endmodule
